// File: rtl/nl_vc_credit_tracker.sv
// -----------------------------------------------------------------------------
// nl_vc_credit_tracker
//   Credit tracker for one router output port, with one credit counter per
//   downstream VC. Each counter starts at BUF_LEN. It decrements when a flit
//   is sent on that VC and increments by credit_num_i when credits come back.
//   The block also keeps a starvation watchdog per VC and sticky protocol-error
//   flags. Every output is decoded from registered state only.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous reset, active-high
//   flit_valid_i    a flit is sent on this output this cycle
//   flit_vc_i       VC index of the sent flit
//   credit_valid_i  credits are returned from downstream this cycle
//   credit_vc_i     VC index of the returned credits
//   credit_num_i    number of credits returned (0 = no-op)
//   err_clr_i       clears starve_o and the err_* sticky flags
//   vc_credits_o    credit count per VC; VC v is in bits [v*CW +: CW]
//   vc_blocked_o    credits[v] == 0
//   vc_almost_o     credits[v] <= ALMOST_TH
//   vc_empty_o      credits[v] == BUF_LEN (downstream buffer drained)
//   starve_o        sticky: VC v held zero credits for TIMEOUT cycles
//   err_underflow_o sticky: a flit was sent with no credit available
//   err_overflow_o  sticky: a credit return would exceed BUF_LEN
//   err_badvc_o     sticky: a valid event carried a VC index >= NV
// -----------------------------------------------------------------------------
module nl_vc_credit_tracker #(
   parameter int NV        = 2,
   parameter int BUF_LEN   = 4,
   parameter int MAX_RET   = 1,
   parameter int ALMOST_TH = 1,
   parameter int TIMEOUT   = 1024,
   localparam int VW = (NV > 1) ? $clog2(NV) : 1,
   localparam int CW = $clog2(BUF_LEN + 1),
   localparam int RW = $clog2(MAX_RET + 1),
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flit_valid_i,
   input  logic [VW-1:0]    flit_vc_i,
   input  logic             credit_valid_i,
   input  logic [VW-1:0]    credit_vc_i,
   input  logic [RW-1:0]    credit_num_i,
   input  logic             err_clr_i,
   output logic [NV*CW-1:0] vc_credits_o,
   output logic [NV-1:0]    vc_blocked_o,
   output logic [NV-1:0]    vc_almost_o,
   output logic [NV-1:0]    vc_empty_o,
   output logic [NV-1:0]    starve_o,
   output logic             err_underflow_o,
   output logic             err_overflow_o,
   output logic             err_badvc_o
);

   // One sign bit above the largest possible credits + return.
   localparam int SW = CW + RW + 1;
   // NV needs one more bit than VW when NV is a power of two.
   localparam logic [VW:0] NV_W = (VW + 1)'(NV);

   logic [NV-1:0] underflow_v;
   logic [NV-1:0] overflow_v;

   for (genvar v = 0; v < NV; v++) begin : g_vc
      logic          snd;
      logic [RW-1:0] ret;
      logic [SW-1:0] sum;
      logic [CW-1:0] credits_d;
      logic [CW-1:0] credits_q;

      // An out-of-range index never equals v, so a bad event is dropped here.
      assign snd = flit_valid_i && (flit_vc_i == VW'(v));
      assign ret = (credit_valid_i && (credit_vc_i == VW'(v))) ? credit_num_i : '0;

      // A send and a return on the same VC net out in one addition.
      assign sum            = SW'(credits_q) + SW'(ret) - SW'(snd);
      assign underflow_v[v] = sum[SW-1];
      assign overflow_v[v]  = !sum[SW-1] && (sum > SW'(BUF_LEN));

      // NOTE: every path assigns credits_d, so this comb block cannot infer a latch.
      always_comb begin
         credits_d = sum[CW-1:0];
         if (underflow_v[v]) begin
            credits_d = '0;
         end else if (overflow_v[v]) begin
            credits_d = CW'(BUF_LEN);
         end
      end

      // NOTE: state registers use non-blocking assignments so that every flop
      // samples the values from before the edge.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            credits_q <= CW'(BUF_LEN);
         end else begin
            credits_q <= credits_d;
         end
      end

      assign vc_credits_o[v*CW +: CW] = credits_q;
      assign vc_blocked_o[v]          = (credits_q == '0);
      assign vc_almost_o[v]           = (credits_q <= CW'(ALMOST_TH));
      assign vc_empty_o[v]            = (credits_q == CW'(BUF_LEN));

      if (TIMEOUT > 0) begin : g_wd
         logic [TW-1:0] wd_q;
         logic          starve_q;
         logic          reach;

         // reach fires only on the step into TIMEOUT. Once wd_q saturates,
         // an err_clr_i clears starve until the VC recovers and starves again.
         assign reach = (credits_q == '0) && (wd_q == TW'(TIMEOUT - 1));

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               wd_q     <= '0;
               starve_q <= 1'b0;
            end else begin
               if (credits_q != '0) begin
                  wd_q <= '0;
               end else if (wd_q != TW'(TIMEOUT)) begin
                  wd_q <= wd_q + 1'b1;
               end
               starve_q <= (starve_q && !err_clr_i) || reach;
            end
         end

         assign starve_o[v] = starve_q;
      end else begin : g_no_wd
         assign starve_o[v] = 1'b0;
      end
   end

   logic badvc;
   assign badvc = (flit_valid_i   && ({1'b0, flit_vc_i}   >= NV_W)) ||
                  (credit_valid_i && ({1'b0, credit_vc_i} >= NV_W));

   // Sticky flags: a new error in the same cycle as err_clr_i wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_underflow_o <= 1'b0;
         err_overflow_o  <= 1'b0;
         err_badvc_o     <= 1'b0;
      end else begin
         err_underflow_o <= (err_underflow_o && !err_clr_i) || (|underflow_v);
         err_overflow_o  <= (err_overflow_o  && !err_clr_i) || (|overflow_v);
         err_badvc_o     <= (err_badvc_o     && !err_clr_i) || badvc;
      end
   end

endmodule

// File: tb/tb_nl_vc_credit_tracker.sv
// -----------------------------------------------------------------------------
// tb_nl_vc_credit_tracker
//   Directed bench for nl_vc_credit_tracker with NV=3, BUF_LEN=4, MAX_RET=3,
//   ALMOST_TH=1 and TIMEOUT=8. A behavioural model (integer credit counts and
//   a run length of zero-credit cycles) is compared against every DUT output
//   after each clock edge. Literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_nl_vc_credit_tracker;
   localparam int NV        = 3;
   localparam int BUF_LEN   = 4;
   localparam int MAX_RET   = 3;
   localparam int ALMOST_TH = 1;
   localparam int TIMEOUT   = 8;
   localparam int VW        = 2;
   localparam int CW        = 3;
   localparam int RW        = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flit_valid = 1'b0;
   logic [VW-1:0]    flit_vc = '0;
   logic             credit_valid = 1'b0;
   logic [VW-1:0]    credit_vc = '0;
   logic [RW-1:0]    credit_num = '0;
   logic             err_clr = 1'b0;
   logic [NV*CW-1:0] vc_credits;
   logic [NV-1:0]    vc_blocked, vc_almost, vc_empty, starve;
   logic             err_underflow, err_overflow, err_badvc;

   always #5 clk = ~clk;

   nl_vc_credit_tracker #(
      .NV(NV), .BUF_LEN(BUF_LEN), .MAX_RET(MAX_RET),
      .ALMOST_TH(ALMOST_TH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .flit_valid_i(flit_valid), .flit_vc_i(flit_vc),
      .credit_valid_i(credit_valid), .credit_vc_i(credit_vc),
      .credit_num_i(credit_num), .err_clr_i(err_clr),
      .vc_credits_o(vc_credits), .vc_blocked_o(vc_blocked),
      .vc_almost_o(vc_almost), .vc_empty_o(vc_empty), .starve_o(starve),
      .err_underflow_o(err_underflow), .err_overflow_o(err_overflow),
      .err_badvc_o(err_badvc)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_cred [NV];
   int m_zrun [NV];   // consecutive cycles spent at zero credits
   bit m_starve [NV];
   bit m_uf, m_of, m_bad;
   bit model_live = 1'b0;

   function automatic void model_step();
      bit nu, no, nb;
      if (rst) begin
         for (int v = 0; v < NV; v++) begin
            m_cred[v]   = BUF_LEN;
            m_zrun[v]   = 0;
            m_starve[v] = 1'b0;
         end
         m_uf = 1'b0; m_of = 1'b0; m_bad = 1'b0;
         model_live = 1'b1;
         return;
      end
      nu = 1'b0; no = 1'b0;
      nb = (flit_valid && int'(flit_vc) >= NV) || (credit_valid && int'(credit_vc) >= NV);
      for (int v = 0; v < NV; v++) begin
         int snd, ret, s;
         snd = (flit_valid && int'(flit_vc) == v) ? 1 : 0;
         ret = (credit_valid && int'(credit_vc) == v) ? int'(credit_num) : 0;
         // Watchdog looks at the count held during this cycle.
         if (m_cred[v] == 0) m_zrun[v]++;
         else m_zrun[v] = 0;
         m_starve[v] = (m_starve[v] && !err_clr) || (m_zrun[v] == TIMEOUT);
         s = m_cred[v] + ret - snd;
         if (s < 0) begin
            m_cred[v] = 0; nu = 1'b1;
         end else if (s > BUF_LEN) begin
            m_cred[v] = BUF_LEN; no = 1'b1;
         end else begin
            m_cred[v] = s;
         end
      end
      m_uf  = (m_uf  && !err_clr) || nu;
      m_of  = (m_of  && !err_clr) || no;
      m_bad = (m_bad && !err_clr) || nb;
   endfunction

   function automatic int cred(input int v);
      return int'(vc_credits[v*CW +: CW]);
   endfunction

   // Single compare process: advance the model on each edge, then check #1 later.
   always @(posedge clk) begin
      model_step();
      #1;
      if (model_live) begin
         for (int v = 0; v < NV; v++) begin
            check($sformatf("credits[%0d]", v), cred(v), m_cred[v]);
            check($sformatf("blocked[%0d]", v), vc_blocked[v], m_cred[v] == 0);
            check($sformatf("almost[%0d]", v), vc_almost[v], m_cred[v] <= ALMOST_TH);
            check($sformatf("empty[%0d]", v), vc_empty[v], m_cred[v] == BUF_LEN);
            check($sformatf("starve[%0d]", v), starve[v], m_starve[v]);
         end
         check("err_underflow", err_underflow, m_uf);
         check("err_overflow", err_overflow, m_of);
         check("err_badvc", err_badvc, m_bad);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input bit fv, input int fvc, input bit cv, input int cvc,
                       input int cn, input bit clr);
      @(negedge clk);
      flit_valid   = fv;
      flit_vc      = VW'(fvc);
      credit_valid = cv;
      credit_vc    = VW'(cvc);
      credit_num   = RW'(cn);
      err_clr      = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int v);           tick(1'b1, v, 1'b0, 0, 0, 1'b0); endtask
   task automatic give(input int v, input int n); tick(1'b0, 0, 1'b1, v, n, 1'b0); endtask
   task automatic clear();                     tick(1'b0, 0, 1'b0, 0, 0, 1'b1); endtask
   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst credits0", cred(0), 4);
      check("rst credits1", cred(1), 4);
      check("rst credits2", cred(2), 4);
      check("rst empty", vc_empty, 3'b111);
      check("rst blocked", vc_blocked, 3'b000);
      check("rst almost", vc_almost, 3'b000);
      check("rst errs", {err_underflow, err_overflow, err_badvc}, 3'b000);

      // Back-to-back sends on VC1, then underflow
      send(1); check("vc1 step1", cred(1), 3);
      send(1); check("vc1 step2", cred(1), 2);
      check("vc1 almost@2", vc_almost[1], 1'b0);
      send(1); check("vc1 step3", cred(1), 1);
      check("vc1 almost@1", vc_almost[1], 1'b1);
      check("vc1 not blocked@1", vc_blocked[1], 1'b0);
      send(1); check("vc1 step4", cred(1), 0);
      check("vc1 blocked", vc_blocked[1], 1'b1);
      send(1); check("vc1 underflow stays 0", cred(1), 0);
      check("underflow flag", err_underflow, 1'b1);
      give(1, 3); give(1, 1);
      check("vc1 restored", cred(1), 4);
      clear(); check("underflow cleared", err_underflow, 1'b0);

      // Same-VC net-out and cross-VC independence
      send(0); send(0);
      check("vc0 at 2", cred(0), 2);
      tick(1'b1, 0, 1'b1, 0, 1, 1'b0);
      check("vc0 net-out", cred(0), 2);
      send(1);
      tick(1'b1, 0, 1'b1, 1, 1, 1'b0);
      check("vc0 -1", cred(0), 1);
      check("vc1 +1", cred(1), 4);

      // Multi-credit return with saturation
      give(0, 2); check("vc0 at 3", cred(0), 3);
      give(0, 3); check("vc0 saturated", cred(0), 4);
      check("overflow flag", err_overflow, 1'b1);
      clear(); check("overflow cleared", err_overflow, 1'b0);

      // Watchdog: 8 cycles at zero sets starve[0]
      repeat (4) send(0);
      idle(7); check("starve0 after 7", starve[0], 1'b0);
      idle(1); check("starve0 after 8", starve[0], 1'b1);
      clear(); check("starve0 cleared", starve[0], 1'b0);
      give(0, 3); give(0, 1);
      check("vc0 refilled", cred(0), 4);

      // Watchdog restart: a credit after 7 zero cycles avoids starve
      repeat (4) send(0);
      idle(6);
      give(0, 1);
      check("vc0 rescued", cred(0), 1);
      check("starve0 not set", starve[0], 1'b0);
      send(0);
      idle(7); check("restart 7", starve[0], 1'b0);
      idle(1); check("restart 8", starve[0], 1'b1);
      clear(); give(0, 3); give(0, 1);

      // Invalid VC index
      send(3);
      check("badvc flag", err_badvc, 1'b1);
      check("badvc credits0", cred(0), 4);
      check("badvc credits1", cred(1), 4);
      check("badvc credits2", cred(2), 4);
      tick(1'b1, 0, 1'b1, 3, 1, 1'b0);
      check("badvc other event applied", cred(0), 3);
      clear(); check("badvc cleared", err_badvc, 1'b0);
      give(0, 1);

      // Reset mid-stream, with a send present during the reset cycle
      send(2); send(2);
      check("vc2 at 2", cred(2), 2);
      @(negedge clk);
      rst = 1'b1; flit_valid = 1'b1; flit_vc = 2'd2;
      @(posedge clk); #2;
      check("midrst credits2", cred(2), 4);
      check("midrst empty", vc_empty, 3'b111);
      @(negedge clk);
      rst = 1'b0; flit_valid = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
